prio_arb_enc: RTL and testbench

- Parametrised, registered N-input priority encoder/arbiter. Successor to the team's fixed 4-input priority encoder.
- Adds generic width, a runtime-selectable round-robin mode, one-hot grant output and a valid/ready output handshake.
- Sits between a bank of request sources and a single downstream consumer. Each grant is held stable until the consumer accepts it.

---
 rtl/prio_arb_pkg.sv | 18 +
 rtl/prio_pick.sv | 43 ++++
 rtl/prio_arb_enc.sv | 107 ++++++++++
 tb/tb_prio_arb_enc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_arb_pkg
// Purpose  : Shared state encoding and mode constants for prio_arb_enc.
// Revision : 1.0
// ============================================================================
package prio_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// ============================================================================
// Module   : prio_pick
// Purpose  : Combinational winner search, fixed priority or rotating from ptr.
// Revision : 1.0
// ============================================================================
module prio_pick
    import prio_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  logic            rr_mode,
    output logic [IDXW-1:0] idx,
    output logic [N-1:0]    onehot,
    output logic            any
);

    always_comb begin
        int base;
        int pos;
        idx  = '0;
        base = (rr_mode == MODE_RR) ? int'(ptr) : 0;
        pos  = 0;
        // Walk from lowest to highest priority so the last hit is the winner;
        // a zero base makes the order N-1..0, i.e. plain fixed priority.
        for (int k = N; k >= 1; k--) begin
            pos = base - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            if (req[pos]) begin
                idx = IDXW'(pos);
            end
        end
        any    = |req;
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/prio_arb_enc.sv
`default_nettype none
// ============================================================================
// Module   : prio_arb_enc
// Purpose  : Registered N-input arbiter with sticky grant and valid/ready output.
// Revision : 1.0
// ============================================================================
module prio_arb_enc
    import prio_arb_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            rr_mode,
    input  logic            out_ready,
    output logic            valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot
);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [N-1:0]      onehot_q, onehot_d;

    logic [IDXW-1:0]   w_pick_ptr;
    logic [IDXW-1:0]   w_pick_idx;
    logic [N-1:0]      w_pick_onehot;
    logic              w_pick_any;

    // In HOLD the pick is only consumed on a handshake, where ptr becomes the
    // granted index in the same edge, so search from idx_q directly.
    assign w_pick_ptr = (state_q == HOLD) ? idx_q : ptr_q;

    prio_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .ptr     (w_pick_ptr),
        .rr_mode (rr_mode),
        .idx     (w_pick_idx),
        .onehot  (w_pick_onehot),
        .any     (w_pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    idx_d    = w_pick_idx;
                    onehot_d = w_pick_onehot;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ptr_d = idx_q;
                    if (w_pick_any) begin
                        idx_d    = w_pick_idx;
                        onehot_d = w_pick_onehot;
                    end else begin
                        valid_d  = 1'b0;
                        onehot_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign valid      = valid_q;
    assign gnt_idx    = idx_q;
    assign gnt_onehot = onehot_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arb_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_arb_enc
// Purpose  : Directed self-checking bench for prio_arb_enc with N=4.
// Revision : 1.0
// ============================================================================
module tb_prio_arb_enc;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic            rr_mode;
    logic            out_ready;
    logic            valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_onehot;

    int checks   = 0;
    int failures = 0;

    prio_arb_enc #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rr_mode    (rr_mode),
        .out_ready  (out_ready),
        .valid      (valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic apply_reset();
        rst_n = 1'b0; req = '0; rr_mode = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({valid, gnt_idx, gnt_onehot} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b idx=%0d oh=%b, want 0/0/0000", valid, gnt_idx, gnt_onehot);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_noreq: got valid=%b, want 0", valid);
        end
    endtask

    task automatic test_fixed();
        apply_reset();
        req = 4'b0110;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL fixed_no_comb_path: got valid=%b, want 0", valid);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd2 || gnt_onehot !== 4'b0100) begin
            failures++;
            $display("FAIL fixed_grant: got valid=%b idx=%0d oh=%b, want 1/2/0100", valid, gnt_idx, gnt_onehot);
        end
        req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || gnt_idx !== 2'd2 || gnt_onehot !== 4'b0100) begin
                failures++;
                $display("FAIL fixed_sticky[%0d]: got valid=%b idx=%0d oh=%b, want 1/2/0100", c, valid, gnt_idx, gnt_onehot);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 4'b1001;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || gnt_idx !== 2'd3 || gnt_onehot !== 4'b1000) begin
                failures++;
                $display("FAIL b2b_fixed[%0d]: got valid=%b idx=%0d oh=%b, want 1/3/1000", c, valid, gnt_idx, gnt_onehot);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [IDXW-1:0] exp_seq [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        logic [N-1:0]    exp_oh;
        apply_reset();
        rr_mode = 1'b1;
        req = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_oh = 4'b0001 << exp_seq[c];
            checks++;
            if (valid !== 1'b1 || gnt_idx !== exp_seq[c] || gnt_onehot !== exp_oh) begin
                failures++;
                $display("FAIL rr_seq[%0d]: got valid=%b idx=%0d oh=%b, want 1/%0d/%b", c, valid, gnt_idx, gnt_onehot, exp_seq[c], exp_oh);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_rr_skip();
        logic [IDXW-1:0] exp_seq [3] = '{2'd0, 2'd2, 2'd0};
        apply_reset();
        rr_mode = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd2) begin
            failures++;
            $display("FAIL rr_skip_setup: got valid=%b idx=%0d, want 1/2", valid, gnt_idx);
        end
        req = 4'b0101;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || gnt_idx !== exp_seq[c]) begin
                failures++;
                $display("FAIL rr_skip[%0d]: got valid=%b idx=%0d, want 1/%0d", c, valid, gnt_idx, exp_seq[c]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_drain_mode();
        apply_reset();
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd1) begin
            failures++;
            $display("FAIL drain_setup: got valid=%b idx=%0d, want 1/1", valid, gnt_idx);
        end
        req = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || gnt_onehot !== 4'b0000 || gnt_idx !== 2'd1) begin
            failures++;
            $display("FAIL drain: got valid=%b idx=%0d oh=%b, want 0/1/0000", valid, gnt_idx, gnt_onehot);
        end
        out_ready = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd3) begin
            failures++;
            $display("FAIL mode_fixed_grant: got valid=%b idx=%0d, want 1/3", valid, gnt_idx);
        end
        rr_mode = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd3 || gnt_onehot !== 4'b1000) begin
            failures++;
            $display("FAIL mode_toggle_hold: got valid=%b idx=%0d oh=%b, want 1/3/1000", valid, gnt_idx, gnt_onehot);
        end
        // Handshake on 3 in round-robin: search 2,1,0,3 over 1010 -> 1.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd1 || gnt_onehot !== 4'b0010) begin
            failures++;
            $display("FAIL mode_rr_next: got valid=%b idx=%0d oh=%b, want 1/1/0010", valid, gnt_idx, gnt_onehot);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd2) begin
            failures++;
            $display("FAIL areset_setup: got valid=%b idx=%0d, want 1/2", valid, gnt_idx);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, gnt_idx, gnt_onehot} !== 7'b0) begin
            failures++;
            $display("FAIL areset_immediate: got valid=%b idx=%0d oh=%b, want 0/0/0000", valid, gnt_idx, gnt_onehot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || gnt_onehot !== 4'b0000) begin
            failures++;
            $display("FAIL areset_no_replay: got valid=%b oh=%b, want 0/0000", valid, gnt_onehot);
        end
        // ptr must be back at 0: round-robin from reset matches fixed order.
        rr_mode = 1'b1;
        req = 4'b1001;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || gnt_idx !== 2'd3) begin
            failures++;
            $display("FAIL areset_ptr: got valid=%b idx=%0d, want 1/3", valid, gnt_idx);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; rr_mode = 1'b0; out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_back_to_back();
        test_round_robin();
        test_rr_skip();
        test_drain_mode();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
